// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the execute stage and a word-wide data memory.
// Splits word-straddling accesses into two beats and aligns/extends the data.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        split_q, split_d;
  logic [3:0]  be_hi_q, be_hi_d;
  logic [31:0] wdata_hi_q, wdata_hi_d;
  logic [31:0] addr_hi_q, addr_hi_d;
  logic [31:0] rd0_q, rd0_d;

  // Lane math on the incoming request, so ACC0 outputs are ready the cycle after accept
  logic [3:0]  mask_in;
  logic [7:0]  be8_in;
  logic [63:0] w64_in;
  logic        illegal_in;

  always_comb begin
    unique case (req_funct3[1:0])
      2'd0:    mask_in = 4'b0001;
      2'd1:    mask_in = 4'b0011;
      default: mask_in = 4'b1111;
    endcase
    be8_in     = {4'b0000, mask_in} << req_addr[1:0];
    w64_in     = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    illegal_in = (req_funct3[1:0] == 2'b11) || (req_store && req_funct3[2]);
  end

  // Final read word arrives on the ack edge, so it bypasses rd0/rd1 registers
  logic [31:0] lo_word, hi_word, r32, load_ext;

  always_comb begin
    lo_word = (state_q == StAcc0) ? mem_rdata : rd0_q;
    hi_word = (state_q == StAcc0) ? 32'h0 : mem_rdata;
    r32     = 32'({hi_word, lo_word} >> {off_q, 3'b000});
    unique case (funct3_q[1:0])
      2'd0:    load_ext = funct3_q[2] ? {24'h0, r32[7:0]} : {{24{r32[7]}}, r32[7:0]};
      2'd1:    load_ext = funct3_q[2] ? {16'h0, r32[15:0]} : {{16{r32[15]}}, r32[15:0]};
      default: load_ext = r32;
    endcase
  end

  logic        go_resp, go_err;
  logic [15:0] cnt_inc;

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cnt_d        = cnt_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    split_d      = split_q;
    be_hi_d      = be_hi_q;
    wdata_hi_d   = wdata_hi_q;
    addr_hi_d    = addr_hi_q;
    rd0_d        = rd0_q;
    go_resp      = 1'b0;
    go_err       = 1'b0;
    cnt_inc      = cnt_q + 16'd1;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          store_d     = req_store;
          funct3_d    = req_funct3;
          off_d       = req_addr[1:0];
          if (illegal_in) begin
            go_resp = 1'b1;
            go_err  = 1'b1;
          end else begin
            state_d     = StAcc0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_store;
            mem_be_d    = be8_in[3:0];
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = req_store ? w64_in[31:0] : 32'h0;
            be_hi_d     = be8_in[7:4];
            wdata_hi_d  = req_store ? w64_in[63:32] : 32'h0;
            addr_hi_d   = {req_addr[31:2], 2'b00} + 32'd4;
            split_d     = |be8_in[7:4];
            cnt_d       = 16'd0;
          end
        end
      end
      StAcc0, StAcc1: begin
        if (mem_ack) begin
          if (state_q == StAcc0 && split_q) begin
            // Second beat follows back-to-back; mem_req stays high
            state_d     = StAcc1;
            rd0_d       = mem_rdata;
            mem_be_d    = be_hi_q;
            mem_addr_d  = addr_hi_q;
            mem_wdata_d = wdata_hi_q;
            cnt_d       = 16'd0;
          end else begin
            go_resp = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
          if (TIMEOUT != 0 && cnt_inc == TimeoutCnt) begin
            go_resp = 1'b1;
            go_err  = 1'b1;
          end
        end
      end
      StResp: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (go_resp) begin
      state_d      = StResp;
      resp_valid_d = 1'b1;
      resp_err_d   = go_err;
      resp_rdata_d = (go_err || store_q) ? 32'h0 : load_ext;
      mem_req_d    = 1'b0;
      mem_we_d     = 1'b0;
      mem_be_d     = 4'b0000;
      mem_addr_d   = 32'h0;
      mem_wdata_d  = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      cnt_q        <= 16'd0;
      store_q      <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      split_q      <= 1'b0;
      be_hi_q      <= 4'b0000;
      wdata_hi_q   <= 32'h0;
      addr_hi_q    <= 32'h0;
      rd0_q        <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cnt_q        <= cnt_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      split_q      <= split_d;
      be_hi_q      <= be_hi_d;
      wdata_hi_q   <= wdata_hi_d;
      addr_hi_q    <= addr_hi_d;
      rd0_q        <= rd0_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: expected accesses/responses are queued at issue time
// and checked by the memory model and a response monitor.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  lsu_mem_ctrl #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} acc_t;
  typedef struct {logic [31:0] rdata; logic err;} rsp_t;

  acc_t        exp_acc[$];
  rsp_t        exp_rsp[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          failures = 0;
  int          req_cycles = 0;
  int          ack_delay = 0;
  bit          ack_en = 1'b1;
  bit          force_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rdw(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic exp_access(input logic we, input logic [3:0] be, input logic [31:0] a,
                            input logic [31:0] wd);
    acc_t e;
    e.we = we; e.be = be; e.addr = a; e.wdata = wd;
    exp_acc.push_back(e);
  endtask

  // Memory model: acks after ack_delay waiting cycles and checks each accepted access
  initial begin
    int   wait_cnt;
    acc_t e;
    logic [31:0] w;
    wait_cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      if (mem_req === 1'b1) req_cycles++;
      if (force_ack) begin
        mem_ack = 1'b1;
      end else if (mem_req === 1'b1 && ack_en) begin
        if (wait_cnt >= ack_delay) begin
          wait_cnt = 0;
          if (exp_acc.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mem_unexpected actual=addr %h required=no access", mem_addr);
          end else begin
            e = exp_acc.pop_front();
            chk("mem_we", {31'h0, mem_we}, {31'h0, e.we});
            chk("mem_be", {28'h0, mem_be}, {28'h0, e.be});
            chk("mem_addr", mem_addr, e.addr);
            if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          end
          if (mem_we) begin
            w = rdw(mem_addr);
            for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            mem[mem_addr] = w;
          end else begin
            mem_rdata = rdw(mem_addr);
          end
          mem_ack = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected actual=rdata %h err %b required=no response",
                   resp_rdata, resp_err);
        end else begin
          r = exp_rsp.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
        end
      end
    end
  end

  task automatic issue(input string name, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                       input logic ee, input int el);
    rsp_t r;
    int   lat;
    r.rdata = er;
    r.err = ee;
    exp_rsp.push_back(r);
    @(negedge clk);
    chk({name, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    lat = 1;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (resp_valid !== 1'b1 && lat < 64);
    if (resp_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no resp_valid required=resp_valid", name);
    end else if (el != 0) begin
      chk({name, "_latency"}, 32'(lat), 32'(el));
    end
    chk({name, "_acc_left"}, 32'(exp_acc.size()), 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_ctl", {26'h0, mem_req, mem_we, mem_be}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    mem[32'h100] = 32'hDEADBEEF;
    exp_access(1'b0, 4'b1111, 32'h100, 32'h0);
    issue("lw_aligned", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    repeat (2) @(negedge clk);
    chk("rdata_hold", resp_rdata, 32'hDEADBEEF);

    exp_access(1'b1, 4'b1000, 32'h100, 32'hA5000000);
    issue("sb_lane3", 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1'b0, 3);
    exp_access(1'b0, 4'b1111, 32'h100, 32'h0);
    issue("lw_after_sb", 1'b0, 3'b010, 32'h100, 32'h0, 32'hA5ADBEEF, 1'b0, 3);

    mem[32'h100] = 32'h80000000;
    mem[32'h104] = 32'h00000012;
    exp_access(1'b0, 4'b1000, 32'h100, 32'h0);
    exp_access(1'b0, 4'b0001, 32'h104, 32'h0);
    issue("lh_split", 1'b0, 3'b001, 32'h103, 32'h0, 32'h00001280, 1'b0, 4);
    exp_access(1'b0, 4'b1000, 32'h100, 32'h0);
    exp_access(1'b0, 4'b0001, 32'h104, 32'h0);
    issue("lhu_split", 1'b0, 3'b101, 32'h103, 32'h0, 32'h00001280, 1'b0, 4);

    mem[32'h100] = 32'h12803456;
    exp_access(1'b0, 4'b0110, 32'h100, 32'h0);
    issue("lh_off1", 1'b0, 3'b001, 32'h101, 32'h0, 32'hFFFF8034, 1'b0, 3);
    exp_access(1'b0, 4'b0110, 32'h100, 32'h0);
    issue("lhu_off1", 1'b0, 3'b101, 32'h101, 32'h0, 32'h00008034, 1'b0, 3);

    mem[32'h0] = 32'h00800000;
    exp_access(1'b0, 4'b0100, 32'h0, 32'h0);
    issue("lb_neg", 1'b0, 3'b000, 32'h2, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    exp_access(1'b0, 4'b0100, 32'h0, 32'h0);
    issue("lbu", 1'b0, 3'b100, 32'h2, 32'h0, 32'h00000080, 1'b0, 3);

    exp_access(1'b1, 4'b1100, 32'h100, 32'hBEEF0000);
    issue("sh_off2", 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 1'b0, 3);

    // Wrapping split store with a slow memory: each beat waits 2 cycles before ack
    ack_delay = 2;
    exp_access(1'b1, 4'b1100, 32'hFFFFFFFC, 32'h33440000);
    exp_access(1'b1, 4'b0011, 32'h00000000, 32'h00001122);
    issue("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 32'h0, 1'b0, 8);
    ack_delay = 0;
    exp_access(1'b0, 4'b1100, 32'hFFFFFFFC, 32'h0);
    exp_access(1'b0, 4'b0011, 32'h00000000, 32'h0);
    issue("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h11223344, 1'b0, 4);

    req_cycles = 0;
    issue("illegal_sz3", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 0);
    issue("illegal_sbu", 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1, 0);
    chk("illegal_no_mem", 32'(req_cycles), 32'h0);

    ack_en = 1'b0;
    req_cycles = 0;
    issue("timeout", 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b1, 17);
    chk("timeout_req_cycles", 32'(req_cycles), 32'd15);

    // Reset while ACC0 waits, then a stray ack must be ignored
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_in_acc0", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("midrst_ready", {31'h0, req_ready}, 32'h1);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_rdata", resp_rdata, 32'h0);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    ack_en = 1'b1;
    chk("stray_ack_ready", {31'h0, req_ready}, 32'h1);
    chk("stray_ack_no_req", {31'h0, mem_req}, 32'h0);

    mem[32'h300] = 32'hCAFEF00D;
    exp_access(1'b0, 4'b1111, 32'h300, 32'h0);
    issue("lw_after_rst", 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 1'b0, 3);

    repeat (3) @(negedge clk);
    chk("resp_queue_empty", 32'(exp_rsp.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
